// File: rtl/vga_sync.sv
// 640x480@60 VGA timing generator: pixel-rate divider, h/v counters and registered sync/bright decode.
// Optional frame_tick output enabled by defining VGA_FRAME_TICK_EN.
`timescale 1ns/1ps
module vga_sync #(
  parameter int CLK_DIV = 2,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_TOTAL = 800,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 29,
  parameter int V_TOTAL = 521
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       bright
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_FP);
  localparam logic [9:0] HS_END   = 10'(H_FP + H_SYNC);
  localparam logic [9:0] H_VIS    = 10'(H_FP + H_SYNC + H_BP);
  localparam logic [9:0] VS_START = 10'(V_FP);
  localparam logic [9:0] VS_END   = 10'(V_FP + V_SYNC);
  localparam logic [9:0] V_VIS    = 10'(V_FP + V_SYNC + V_BP);

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       bright_q, bright_d;
  logic       pixel_tick_q, pixel_tick_d;
  logic       update;
  logic       frame_wrap;

  always_comb begin
    update       = (div_q == DIV_MAX);
    frame_wrap   = update && (h_q == H_MAX) && (v_q == V_MAX);
    div_d        = div_q;
    h_d          = h_q;
    v_d          = v_q;
    pixel_tick_d = update;

    if (update) begin
      div_d = 4'd0;
      if (h_q == H_MAX) begin
        h_d = 10'd0;
        if (v_q == V_MAX) v_d = 10'd0;
        else              v_d = v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      div_d = div_q + 4'd1;
    end

    // Decode from next-state counts so the registered outputs align with the counters.
    hsync_d  = !((h_d >= HS_START) && (h_d < HS_END));
    vsync_d  = !((v_d >= VS_START) && (v_d < VS_END));
    bright_d = (h_d >= H_VIS) && (v_d >= V_VIS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= 4'd0;
      h_q          <= 10'd0;
      v_q          <= 10'd0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      bright_q     <= 1'b0;
      pixel_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      bright_q     <= bright_d;
      pixel_tick_q <= pixel_tick_d;
    end
  end

  assign pixel_tick = pixel_tick_q;
  assign h_count    = h_q;
  assign v_count    = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign bright     = bright_q;

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick_q, frame_tick_d;

  always_comb begin
    frame_tick_d = frame_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_tick_q <= 1'b0;
    else     frame_tick_q <= frame_tick_d;
  end

  assign frame_tick = frame_tick_q;
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
`endif

endmodule
